pong_game_sequencer: RTL and testbench

Frame-synchronous game controller for the single-player Pong system. Sits between the CRT controller and the game unit: derives a once-per-frame tick from `vsync`, sequences the game through attract, serve, play, miss and game-over phases, and gates ball and paddle motion. It also owns the score, lives and speed-level registers consumed by the game unit and its overlay.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_game_sequencer_frame_edge_detect.sv | 32 +++
 rtl/pong_game_sequencer.sv | 156 +++++++++++++++
 tb/tb_pong_game_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game sequencer: phase encoding, field widths
// and default frame counts.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } phase_t;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned SCORE_W_DEF = 8;

  localparam int unsigned SERVE_FRAMES_DEF   = 60;
  localparam int unsigned MISS_FRAMES_DEF    = 30;
  localparam int unsigned START_LIVES_DEF    = 3;
  localparam int unsigned HITS_PER_LEVEL_DEF = 4;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

endpackage

// File: rtl/pong_game_sequencer_frame_edge_detect.sv
// Edge detectors for vsync (falling edge -> frame tick) and start (rising edge).
module frame_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic vsync,
  input  logic start,
  output logic tick,
  output logic start_rise
);

  logic vsync_q;
  logic start_q;
  logic armed;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vsync_q <= 1'b1;
      start_q <= 1'b1;
      armed   <= 1'b0;
    end else begin
      vsync_q <= vsync;
      start_q <= start;
      armed   <= 1'b1;
    end
  end

  // vsync may already be low when reset releases; the first cycle only loads
  // vsync_q so that level is not mistaken for a fresh falling edge.
  assign tick       = armed & vsync_q & ~vsync;
  assign start_rise = start & ~start_q;

endmodule

// File: rtl/pong_game_sequencer.sv
// Frame-synchronous Pong phase controller owning score, lives and speed level.
// Optional feature macro: PONG_SPEEDUP_EN (level rises every HITS_PER_LEVEL hits).
module pong_game_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES   = SERVE_FRAMES_DEF,
  parameter int unsigned MISS_FRAMES    = MISS_FRAMES_DEF,
  parameter int unsigned START_LIVES    = START_LIVES_DEF,
  parameter int unsigned SCORE_W        = SCORE_W_DEF,
  parameter int unsigned HITS_PER_LEVEL = HITS_PER_LEVEL_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               vsync,
  input  logic               start,
  input  logic               paddle_hit,
  input  logic               ball_miss,
  output logic [STATE_W-1:0] state,
  output logic               frame_tick,
  output logic               ball_reset,
  output logic               ball_move_en,
  output logic               paddle_move_en,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level
);

  localparam int unsigned CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  phase_t             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_d;
  logic [LIVES_W-1:0] lives_d;
  logic [LEVEL_W-1:0] level_d;
  logic               reinit;
  logic               tick;
  logic               start_rise;

  frame_edge_detect u_edge (
    .Clock      (Clock),
    .Reset      (Reset),
    .vsync      (vsync),
    .start      (start),
    .tick       (tick),
    .start_rise (start_rise)
  );

`ifdef PONG_SPEEDUP_EN
  localparam int unsigned HC_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  logic [HC_W-1:0] hits_q, hits_d;
  logic            hit_ok;
  logic            hit_wrap;

  assign hit_ok   = (phase_q == PLAY) & paddle_hit & ~ball_miss;
  assign hit_wrap = hit_ok && (hits_q == HC_W'(HITS_PER_LEVEL - 1));

  always_comb begin
    hits_d = hits_q;
    if (reinit)        hits_d = '0;
    else if (hit_wrap) hits_d = '0;
    else if (hit_ok)   hits_d = hits_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) hits_q <= '0;
    else        hits_q <= hits_d;
  end
`endif

  // The raw tick is consumed by the phase current at that edge only, so a tick
  // that causes a transition is never also counted by the phase it enters.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    score_d = score;
    lives_d = lives;
    level_d = level;
    reinit  = 1'b0;
    case (phase_q)
      IDLE, OVER: begin
        if (start_rise) begin
          phase_d = SERVE;
          reinit  = 1'b1;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            cnt_d   = '0;
            phase_d = PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (ball_miss) begin
          phase_d = MISS;
          lives_d = lives - 1'b1;
          cnt_d   = '0;
        end else if (paddle_hit && (score != '1)) begin
          score_d = score + 1'b1;
        end
      end
      MISS: begin
        if (tick) begin
          if (cnt_q == CNT_W'(MISS_FRAMES - 1)) begin
            cnt_d   = '0;
            phase_d = (lives == '0) ? OVER : SERVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: phase_d = IDLE;
    endcase
`ifdef PONG_SPEEDUP_EN
    if (hit_wrap && (level != LEVEL_MAX)) level_d = level + 1'b1;
`endif
    if (reinit) begin
      score_d = '0;
      lives_d = LIVES_W'(START_LIVES);
      level_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      phase_q        <= IDLE;
      cnt_q          <= '0;
      score          <= '0;
      lives          <= LIVES_W'(START_LIVES);
      level          <= '0;
      frame_tick     <= 1'b0;
      ball_move_en   <= 1'b0;
      paddle_move_en <= 1'b0;
      ball_reset     <= 1'b1;
    end else begin
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      score          <= score_d;
      lives          <= lives_d;
      level          <= level_d;
      frame_tick     <= tick;
      ball_move_en   <= tick && (phase_q == PLAY);
      paddle_move_en <= tick && ((phase_q == SERVE) || (phase_q == PLAY));
      ball_reset     <= (phase_d == IDLE) || (phase_d == SERVE);
    end
  end

  assign state = phase_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed/randomized bench for pong_game_sequencer; expectations come from
// game-rule arithmetic (hits, lives, frames per phase), not from the RTL.
module tb_pong_game_sequencer;

  localparam int SF  = 4;
  localparam int MF  = 3;
  localparam int SL  = 3;
  localparam int SW  = 8;
  localparam int HPL = 4;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_MISS  = 3;
  localparam int S_OVER  = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          vsync = 1'b1;
  logic          start = 1'b0;
  logic          paddle_hit = 1'b0;
  logic          ball_miss = 1'b0;
  logic [2:0]    state;
  logic          frame_tick;
  logic          ball_reset;
  logic          ball_move_en;
  logic          paddle_move_en;
  logic [SW-1:0] score;
  logic [2:0]    lives;
  logic [1:0]    level;

  int n_vec = 0;
  int n_err = 0;
  int ticks = 0;
  int bmes  = 0;
  int pmes  = 0;

  pong_game_sequencer #(
    .SERVE_FRAMES   (SF),
    .MISS_FRAMES    (MF),
    .START_LIVES    (SL),
    .SCORE_W        (SW),
    .HITS_PER_LEVEL (HPL)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .vsync          (vsync),
    .start          (start),
    .paddle_hit     (paddle_hit),
    .ball_miss      (ball_miss),
    .state          (state),
    .frame_tick     (frame_tick),
    .ball_reset     (ball_reset),
    .ball_move_en   (ball_move_en),
    .paddle_move_en (paddle_move_en),
    .score          (score),
    .lives          (lives),
    .level          (level)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_level(input int h);
`ifdef PONG_SPEEDUP_EN
    return (h / HPL > 3) ? 3 : h / HPL;
`else
    return 0;
`endif
  endfunction

  function automatic int sat_score(input int h);
    return (h > 255) ? 255 : h;
  endfunction

  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      if (frame_tick === 1'b1)     ticks++;
      if (ball_move_en === 1'b1)   bmes++;
      if (paddle_move_en === 1'b1) pmes++;
      if ((ball_move_en | paddle_move_en) === 1'b1)
        chk("strobe_with_tick", 32'(frame_tick), 1);
    end
  end

  // All stimulus tasks start and end at 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic frame();
    vsync = 1'b0;
    cyc(3);
    vsync = 1'b1;
    cyc(6 + int'($urandom_range(0, 4)));
  endtask

  task automatic pulse(input logic h, input logic m, input int gap);
    paddle_hit = h;
    ball_miss  = m;
    cyc(1);
    paddle_hit = 1'b0;
    ball_miss  = 1'b0;
    cyc(gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    cyc(1);
  endtask

  int game_hits;
  int exp_lives;
  int t0, b0, p0, n;

  initial begin
    #1 Reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), S_IDLE);
    chk("rst_score", 32'(score), 0);
    chk("rst_lives", 32'(lives), SL);
    chk("rst_level", 32'(level), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_bme", 32'(ball_move_en), 0);
    chk("rst_pme", 32'(paddle_move_en), 0);
    chk("rst_ball_reset", 32'(ball_reset), 1);
    cyc(2);
    Reset = 1'b1;
    cyc(2);

    // idle frames: ticks only, no motion
    t0 = ticks; b0 = bmes; p0 = pmes;
    repeat (3) frame();
    chk("idle_ticks", 32'(ticks - t0), 3);
    chk("idle_bme", 32'(bmes - b0), 0);
    chk("idle_pme", 32'(pmes - p0), 0);
    chk("idle_state", 32'(state), S_IDLE);
    chk("idle_ball_reset", 32'(ball_reset), 1);

    // serve then play
    cyc(int'($urandom_range(0, 5)));
    pulse_start();
    game_hits = 0;
    exp_lives = SL;
    chk("serve_state", 32'(state), S_SERVE);
    chk("serve_score", 32'(score), 0);
    chk("serve_lives", 32'(lives), SL);
    b0 = bmes; p0 = pmes;
    for (int k = 1; k <= SF; k++) begin
      frame();
      chk("serve_progress", 32'(state), (k < SF) ? S_SERVE : S_PLAY);
    end
    chk("serve_pme", 32'(pmes - p0), SF);
    chk("serve_bme", 32'(bmes - b0), 0);
    chk("play_ball_reset", 32'(ball_reset), 0);
    frame();
    chk("first_move_bme", 32'(bmes - b0), 1);
    chk("first_move_pme", 32'(pmes - p0), SF + 1);

    pulse_start();
    chk("start_in_play_ignored", 32'(state), S_PLAY);

    // hits
    n = int'($urandom_range(5, 9));
    repeat (n) pulse(1'b1, 1'b0, int'($urandom_range(0, 3)));
    game_hits += n;
    chk("hits_score", 32'(score), sat_score(game_hits));
    chk("hits_level", 32'(level), exp_level(game_hits));
    chk("hits_state", 32'(state), S_PLAY);

    // simultaneous hit and miss: miss wins
    pulse(1'b1, 1'b1, 1);
    exp_lives--;
    chk("hm_state", 32'(state), S_MISS);
    chk("hm_score", 32'(score), sat_score(game_hits));
    chk("hm_lives", 32'(lives), exp_lives);
    pulse(1'b1, 1'b0, 1);
    chk("hit_in_miss_ignored", 32'(score), sat_score(game_hits));
    for (int k = 1; k <= MF; k++) begin
      frame();
      chk("miss_progress", 32'(state), (k < MF) ? S_MISS : S_SERVE);
    end
    chk("reserve_score", 32'(score), sat_score(game_hits));
    chk("reserve_level", 32'(level), exp_level(game_hits));
    chk("reserve_lives", 32'(lives), exp_lives);
    chk("reserve_ball_reset", 32'(ball_reset), 1);

    // remaining lives until game over
    while (exp_lives > 0) begin
      repeat (SF) frame();
      chk("life_play", 32'(state), S_PLAY);
      n = int'($urandom_range(0, 3));
      repeat (n) pulse(1'b1, 1'b0, int'($urandom_range(0, 2)));
      game_hits += n;
      pulse(1'b0, 1'b1, 1);
      exp_lives--;
      chk("life_lives", 32'(lives), exp_lives);
      chk("life_score", 32'(score), sat_score(game_hits));
      repeat (MF) frame();
      chk("life_after_miss", 32'(state), (exp_lives == 0) ? S_OVER : S_SERVE);
    end
    chk("over_lives", 32'(lives), 0);
    chk("over_score", 32'(score), sat_score(game_hits));
    chk("over_level", 32'(level), exp_level(game_hits));
    pulse(1'b1, 1'b0, 1);
    chk("hit_in_over_ignored", 32'(score), sat_score(game_hits));

    // restart on the same edge as a vsync fall: that tick belongs to OVER
    p0 = pmes;
    start = 1'b1;
    vsync = 1'b0;
    cyc(1);
    start = 1'b0;
    cyc(2);
    vsync = 1'b1;
    cyc(6);
    game_hits = 0;
    chk("restart_state", 32'(state), S_SERVE);
    chk("restart_score", 32'(score), 0);
    chk("restart_lives", 32'(lives), SL);
    chk("restart_level", 32'(level), 0);
    chk("restart_pme", 32'(pmes - p0), 0);
    repeat (SF - 1) frame();
    chk("coincident_not_counted", 32'(state), S_SERVE);
    frame();
    chk("coincident_play", 32'(state), S_PLAY);

    // score saturation
    repeat (260) pulse(1'b1, 1'b0, 1);
    game_hits += 260;
    chk("sat_score", 32'(score), sat_score(game_hits));
    chk("sat_level", 32'(level), exp_level(game_hits));

    // asynchronous reset mid-play, with vsync already low
    #3;
    vsync = 1'b0;
    Reset = 1'b0;
    #1;
    chk("async_state", 32'(state), S_IDLE);
    chk("async_score", 32'(score), 0);
    chk("async_lives", 32'(lives), SL);
    chk("async_level", 32'(level), 0);
    chk("async_ball_reset", 32'(ball_reset), 1);
    chk("async_tick", 32'(frame_tick), 0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    t0 = ticks;
    cyc(5);
    chk("no_tick_after_reset", 32'(ticks - t0), 0);
    vsync = 1'b1;
    cyc(3);
    vsync = 1'b0;
    cyc(3);
    chk("tick_after_new_edge", 32'(ticks - t0), 1);
    chk("post_reset_state", 32'(state), S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
